// File: rtl/vga_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | vga_pkg : pattern-mode encoding and 24-bit colour bar palette    |
// | Rev 1.0 : initial release                                        |
// +------------------------------------------------------------------+
package vga_pkg;

  typedef enum logic [1:0] {
    PAT_VBARS = 2'd0,
    PAT_HBARS = 2'd1,
    PAT_CHECK = 2'd2,
    PAT_SOLID = 2'd3
  } pat_mode_e;

  localparam logic [23:0] PALETTE [8] = '{
    24'hFFFFFF,  // white
    24'hFFFF00,  // yellow
    24'h00FFFF,  // cyan
    24'h00FF00,  // green
    24'hFF00FF,  // magenta
    24'hFF0000,  // red
    24'h0000FF,  // blue
    24'h000000   // black
  };

endpackage
`default_nettype wire

// File: rtl/bar_palette.sv
`default_nettype none
// +------------------------------------------------------------------+
// | bar_palette : 3-bit palette index -> full-scale COLOR_W R/G/B    |
// | Rev 1.0 : initial release                                        |
// +------------------------------------------------------------------+
module bar_palette
  import vga_pkg::*;
#(
  parameter int COLOR_W = 8
) (
  input  logic [2:0]         idx,
  output logic [COLOR_W-1:0] red,
  output logic [COLOR_W-1:0] green,
  output logic [COLOR_W-1:0] blue
);

  logic [23:0] rgb24;

  // Palette channels are only ever 00 or FF, so the MSB fully describes each.
  always_comb begin
    rgb24 = PALETTE[idx];
    red   = {COLOR_W{rgb24[23]}};
    green = {COLOR_W{rgb24[15]}};
    blue  = {COLOR_W{rgb24[7]}};
  end

endmodule
`default_nettype wire

// File: rtl/color_bar_gen.sv
`default_nettype none
// +------------------------------------------------------------------+
// | color_bar_gen : frame-latched VGA test pattern generator         |
// | Rev 1.0 : initial release                                        |
// +------------------------------------------------------------------+
module color_bar_gen
  import vga_pkg::*;
#(
  parameter int HVID        = 640,
  parameter int VVID        = 480,
  parameter int NUM_BARS    = 8,
  parameter int COLOR_W     = 8,
  parameter int SCROLL_STEP = 4
) (
  input  logic               clk_25,
  input  logic               rst_n,
  input  logic               load_enable,
  input  logic [9:0]         horizontal_num,
  input  logic [9:0]         vertical_num,
  input  logic               frame_start,
  input  logic [1:0]         mode,
  input  logic [2:0]         solid_sel,
  input  logic               scroll_en,
  output logic [COLOR_W-1:0] red,
  output logic [COLOR_W-1:0] green,
  output logic [COLOR_W-1:0] blue
);

  localparam int XW    = $clog2(2 * HVID);
  localparam int BAR_W = HVID / NUM_BARS;
  localparam int BAR_H = VVID / NUM_BARS;

  generate
    if ((HVID % NUM_BARS) != 0 || (VVID % NUM_BARS) != 0) begin : g_bad_bars
      $error("HVID and VVID must both be divisible by NUM_BARS");
    end
    if (SCROLL_STEP >= HVID) begin : g_bad_step
      $error("SCROLL_STEP must be smaller than HVID");
    end
  endgenerate

  pat_mode_e         act_mode, mode_use;
  logic [2:0]        act_sel, sel_use;
  logic [XW-1:0]     scroll_off, off_sum, off_next, off_use;
  logic [XW-1:0]     x_sum, x;
  logic [2:0]        bx, by, idx;
  logic              blank;
  logic [COLOR_W-1:0] pal_r, pal_g, pal_b;

  // The frame_start pixel already sees the values being latched on that edge.
  always_comb begin
    off_sum  = scroll_off + XW'(SCROLL_STEP);
    off_next = (off_sum >= XW'(HVID)) ? off_sum - XW'(HVID) : off_sum;
    off_use  = (frame_start && scroll_en) ? off_next : scroll_off;
    mode_use = frame_start ? pat_mode_e'(mode) : act_mode;
    sel_use  = frame_start ? solid_sel : act_sel;
  end

  always_comb begin
    x_sum = XW'(horizontal_num) + off_use;
    x     = (x_sum >= XW'(HVID)) ? x_sum - XW'(HVID) : x_sum;
    bx    = 3'(x / XW'(BAR_W));
    by    = 3'(vertical_num / 10'(BAR_H));
    blank = load_enable || (XW'(horizontal_num) >= XW'(HVID)) ||
            (XW'(vertical_num) >= XW'(VVID));
  end

  // Checker cells with even bx+by are white, so the top-left cell is white.
  always_comb begin
    idx = 3'd7;
    case (mode_use)
      PAT_VBARS: idx = bx;
      PAT_HBARS: idx = by;
      PAT_CHECK: idx = (bx[0] ^ by[0]) ? 3'd7 : 3'd0;
      PAT_SOLID: idx = sel_use;
      default:   idx = 3'd7;
    endcase
  end

  bar_palette #(
    .COLOR_W (COLOR_W)
  ) u_palette (
    .idx   (idx),
    .red   (pal_r),
    .green (pal_g),
    .blue  (pal_b)
  );

  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      act_mode   <= PAT_VBARS;
      act_sel    <= 3'd0;
      scroll_off <= '0;
    end else if (frame_start) begin
      act_mode <= pat_mode_e'(mode);
      act_sel  <= solid_sel;
      if (scroll_en) begin
        scroll_off <= off_next;
      end
    end
  end

  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      red   <= '0;
      green <= '0;
      blue  <= '0;
    end else if (blank) begin
      red   <= '0;
      green <= '0;
      blue  <= '0;
    end else begin
      red   <= pal_r;
      green <= pal_g;
      blue  <= pal_b;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_color_bar_gen.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_color_bar_gen : directed vector bench for color_bar_gen       |
// | Rev 1.0 : initial release                                        |
// +------------------------------------------------------------------+
module tb_color_bar_gen;

  typedef struct {
    string       name;
    logic [9:0]  h;
    logic [9:0]  v;
    logic [1:0]  mode;
    logic [2:0]  sel;
    logic        scr;
    logic        fs;
    logic        le;
    logic [23:0] exp_rgb;
  } vec_t;

  logic       clk_25 = 1'b0;
  logic       rst_n = 1'b1;
  logic       load_enable = 1'b0;
  logic [9:0] horizontal_num = '0;
  logic [9:0] vertical_num = '0;
  logic       frame_start = 1'b0;
  logic [1:0] mode = '0;
  logic [2:0] solid_sel = '0;
  logic       scroll_en = 1'b0;
  logic [7:0] red, green, blue;

  int n_checks = 0;
  int n_fail   = 0;
  vec_t tbl[$];

  always #20 clk_25 = ~clk_25;

  color_bar_gen dut (
    .clk_25         (clk_25),
    .rst_n          (rst_n),
    .load_enable    (load_enable),
    .horizontal_num (horizontal_num),
    .vertical_num   (vertical_num),
    .frame_start    (frame_start),
    .mode           (mode),
    .solid_sel      (solid_sel),
    .scroll_en      (scroll_en),
    .red            (red),
    .green          (green),
    .blue           (blue)
  );

  function automatic vec_t mk(input string name, input int h, input int v,
                              input int md, input int sel, input bit scr,
                              input bit fs, input bit le, input logic [23:0] e);
    vec_t r;
    r.name = name; r.h = 10'(h); r.v = 10'(v); r.mode = 2'(md); r.sel = 3'(sel);
    r.scr = scr; r.fs = fs; r.le = le; r.exp_rgb = e;
    return r;
  endfunction

  task automatic check(input string name, input logic [23:0] exp_rgb);
    n_checks++;
    if ({red, green, blue} !== exp_rgb) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, {red, green, blue}, exp_rgb);
    end
  endtask

  // Present one pixel on the falling edge, let the rising edge register it.
  task automatic drive(input vec_t t);
    @(negedge clk_25);
    horizontal_num = t.h; vertical_num = t.v; mode = t.mode; solid_sel = t.sel;
    scroll_en = t.scr; frame_start = t.fs; load_enable = t.le;
    @(posedge clk_25);
    #1;
  endtask

  task automatic run_vec(input vec_t t);
    drive(t);
    check(t.name, t.exp_rgb);
  endtask

  task automatic run_table();
    foreach (tbl[i]) run_vec(tbl[i]);
    tbl.delete();
  endtask

  task automatic frames(input int n, input int md, input bit scr);
    for (int i = 0; i < n; i++) drive(mk("frame", 700, 490, md, 0, scr, 1'b1, 1'b0, 24'h0));
  endtask

  task automatic pulse_reset(input string name);
    #5 rst_n = 1'b0;
    #1 check(name, 24'h000000);
    @(negedge clk_25);
    rst_n = 1'b1;
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #5 check("reset_state", 24'h000000);
    @(negedge clk_25);
    rst_n = 1'b1;

    run_vec(mk("first_px_white", 0, 0, 0, 0, 0, 1, 0, 24'hFFFFFF));

    tbl.push_back(mk("vbar_h79", 79, 0, 0, 0, 0, 0, 0, 24'hFFFFFF));
    tbl.push_back(mk("vbar_h80", 80, 0, 0, 0, 0, 0, 0, 24'hFFFF00));
    tbl.push_back(mk("vbar_h639", 639, 0, 0, 0, 0, 0, 0, 24'h000000));
    tbl.push_back(mk("vbar_h640", 640, 0, 0, 0, 0, 0, 0, 24'h000000));
    tbl.push_back(mk("vbar_h160", 160, 100, 0, 0, 0, 0, 0, 24'h00FFFF));
    tbl.push_back(mk("vbar_v480", 300, 480, 0, 0, 0, 0, 0, 24'h000000));
    tbl.push_back(mk("vbar_blank", 400, 10, 0, 0, 0, 0, 1, 24'h000000));
    tbl.push_back(mk("vbar_h400", 400, 10, 0, 0, 0, 0, 0, 24'hFF0000));
    tbl.push_back(mk("vbar_h80_pre_rst", 80, 0, 0, 0, 0, 0, 0, 24'hFFFF00));
    run_table();
    pulse_reset("reset_midline");

    frames(19, 0, 1'b1);
    run_vec(mk("scroll_fs_px", 0, 0, 0, 0, 1, 1, 0, 24'hFFFF00));
    tbl.push_back(mk("scroll_h0", 0, 5, 0, 0, 1, 0, 0, 24'hFFFF00));
    tbl.push_back(mk("scroll_h600", 600, 5, 0, 0, 1, 0, 0, 24'hFFFFFF));
    tbl.push_back(mk("scroll_h559", 559, 5, 0, 0, 1, 0, 0, 24'h000000));
    run_table();
    frames(139, 0, 1'b1);
    run_vec(mk("scroll_wrap_fs", 0, 0, 0, 0, 1, 1, 0, 24'hFFFFFF));
    run_vec(mk("scroll_wrap_h80", 80, 0, 0, 0, 0, 0, 0, 24'hFFFF00));
    frames(1, 0, 1'b0);
    run_vec(mk("scroll_hold_h80", 80, 0, 0, 0, 0, 0, 0, 24'hFFFF00));

    frames(20, 1, 1'b1);
    tbl.push_back(mk("hbar_v59", 0, 59, 1, 0, 1, 0, 0, 24'hFFFFFF));
    tbl.push_back(mk("hbar_v60", 0, 60, 1, 0, 1, 0, 0, 24'hFFFF00));
    tbl.push_back(mk("hbar_v60_h600", 600, 60, 1, 0, 1, 0, 0, 24'hFFFF00));
    tbl.push_back(mk("hbar_v60_h639", 639, 60, 1, 0, 1, 0, 0, 24'hFFFF00));
    tbl.push_back(mk("hbar_v300", 10, 300, 1, 0, 1, 0, 0, 24'hFF0000));
    tbl.push_back(mk("hbar_v479", 5, 479, 1, 0, 1, 0, 0, 24'h000000));
    run_table();
    pulse_reset("reset_again");

    tbl.push_back(mk("chk_fs_0_0", 0, 0, 2, 0, 0, 1, 0, 24'hFFFFFF));
    tbl.push_back(mk("chk_80_0", 80, 0, 2, 0, 0, 0, 0, 24'h000000));
    tbl.push_back(mk("chk_80_60", 80, 60, 2, 0, 0, 0, 0, 24'hFFFFFF));
    tbl.push_back(mk("chk_0_60", 0, 60, 2, 0, 0, 0, 0, 24'h000000));
    tbl.push_back(mk("chk_639_479", 639, 479, 2, 0, 0, 0, 0, 24'hFFFFFF));
    run_table();

    tbl.push_back(mk("solid_pre_fs", 80, 0, 0, 0, 0, 1, 0, 24'hFFFF00));
    tbl.push_back(mk("solid_no_latch", 80, 0, 3, 5, 0, 0, 0, 24'hFFFF00));
    tbl.push_back(mk("solid_latch_fs", 80, 0, 3, 5, 0, 1, 0, 24'hFF0000));
    tbl.push_back(mk("solid_blank_h100", 100, 0, 3, 5, 0, 0, 1, 24'h000000));
    tbl.push_back(mk("solid_h100", 100, 0, 3, 5, 0, 0, 0, 24'hFF0000));
    tbl.push_back(mk("solid_sel_no_latch", 100, 0, 3, 6, 0, 0, 0, 24'hFF0000));
    tbl.push_back(mk("solid_h700", 700, 0, 3, 5, 0, 0, 0, 24'h000000));
    tbl.push_back(mk("fs_with_blank", 0, 60, 1, 0, 0, 1, 1, 24'h000000));
    tbl.push_back(mk("after_blank_fs", 0, 60, 1, 0, 0, 0, 0, 24'hFFFF00));
    run_table();

    @(negedge clk_25);
    frame_start = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
